// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter.
// Sends one command byte to the keyboard: inhibits the bus, issues the
// request-to-send, shifts the frame out on device clock falling edges and
// checks the device ACK. Both lines are open-drain; the *_OE outputs pull low.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       iPS2_CLK,
    input  logic       iPS2_DATA,
    input  logic       iSend,
    input  logic [7:0] iData,
    output logic       oPS2_CLK_OE,
    output logic       oPS2_DATA_OE,
    output logic       oBusy,
    output logic       oDone,
    output logic       oError
);

    localparam int InhW = $clog2(INHIBIT_CYCLES + 1);
    localparam int ToW  = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [InhW-1:0] INH_LAST    = InhW'(INHIBIT_CYCLES - 1);
    localparam logic [InhW-1:0] INH_PENULT  = InhW'(INHIBIT_CYCLES - 2);
    localparam logic [ToW-1:0]  TO_LAST     = ToW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_INHIBIT   = 3'd1;
    localparam logic [2:0] ST_START     = 3'd2;
    localparam logic [2:0] ST_BITS      = 3'd3;
    localparam logic [2:0] ST_ACK       = 3'd4;
    localparam logic [2:0] ST_WAIT_IDLE = 3'd5;
    localparam logic [2:0] ST_FAIL      = 3'd6;

    logic                  clkSync_p0, clkSync_p1;
    logic                  dataSync_p0, dataSync_p1;
    logic [FILTER_LEN-1:0] clkShift_p2, dataShift_p2;
    logic                  clkLevel, dataLevel, clkLevelPrev;
    logic                  edgeArmed, clkFall;

    logic [2:0]            state;
    logic [9:0]            frame;
    logic [3:0]            bitIdx;
    logic [InhW-1:0]       inhCnt;
    logic [ToW-1:0]        toCnt;

    // Odd parity over the command byte.
    function automatic logic oddParity(input logic [7:0] d);
        return ~^d;
    endfunction

    // Timeout counter increment that sticks at its maximum.
    function automatic logic [ToW-1:0] satIncTimeout(input logic [ToW-1:0] v);
        if (v == TO_LAST)
            return v;
        return v + ToW'(1);
    endfunction

    // Glitch filter decision: follow only a full run of identical samples.
    function automatic logic filterLevel(input logic [FILTER_LEN-1:0] s, input logic cur);
        if (&s)
            return 1'b1;
        if (~|s)
            return 1'b0;
        return cur;
    endfunction

    // Two-flop synchronizers; the idle bus level is high.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clkSync_p0  <= 1'b1;
            clkSync_p1  <= 1'b1;
            dataSync_p0 <= 1'b1;
            dataSync_p1 <= 1'b1;
        end else begin
            clkSync_p0  <= iPS2_CLK;
            clkSync_p1  <= clkSync_p0;
            dataSync_p0 <= iPS2_DATA;
            dataSync_p1 <= dataSync_p0;
        end
    end

    // Shift-register glitch filters and the delayed clock level for edge detection.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clkShift_p2  <= '1;
            dataShift_p2 <= '1;
            clkLevel     <= 1'b1;
            dataLevel    <= 1'b1;
            clkLevelPrev <= 1'b1;
        end else begin
            clkShift_p2  <= {clkShift_p2[FILTER_LEN-2:0], clkSync_p1};
            dataShift_p2 <= {dataShift_p2[FILTER_LEN-2:0], dataSync_p1};
            clkLevel     <= filterLevel(clkShift_p2, clkLevel);
            dataLevel    <= filterLevel(dataShift_p2, dataLevel);
            clkLevelPrev <= clkLevel;
        end
    end

    // Device clock edges only matter once the bus has been handed to the device;
    // our own inhibit pulse and any device activity while inhibited are ignored.
    assign edgeArmed = (state == ST_START) || (state == ST_BITS) || (state == ST_ACK);
    assign clkFall   = edgeArmed && clkLevelPrev && !clkLevel;

    // Transfer sequencer: inhibit, request-to-send, data bits, ACK, bus idle.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state        <= ST_IDLE;
            frame        <= '0;
            bitIdx       <= '0;
            inhCnt       <= '0;
            toCnt        <= '0;
            oPS2_CLK_OE  <= 1'b0;
            oPS2_DATA_OE <= 1'b0;
            oBusy        <= 1'b0;
            oDone        <= 1'b0;
            oError       <= 1'b0;
        end else begin
            oDone  <= 1'b0;
            oError <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (iSend) begin
                        frame       <= {1'b1, oddParity(iData), iData};
                        inhCnt      <= '0;
                        oPS2_CLK_OE <= 1'b1;
                        oBusy       <= 1'b1;
                        state       <= ST_INHIBIT;
                    end
                end
                ST_INHIBIT: begin
                    inhCnt <= inhCnt + InhW'(1);
                    // Start bit goes low one cycle before CLK is released.
                    if (inhCnt == INH_PENULT)
                        oPS2_DATA_OE <= 1'b1;
                    if (inhCnt == INH_LAST) begin
                        oPS2_CLK_OE  <= 1'b0;
                        oPS2_DATA_OE <= 1'b1;
                        toCnt        <= '0;
                        bitIdx       <= '0;
                        state        <= ST_START;
                    end
                end
                ST_START, ST_BITS, ST_ACK: begin
                    // Timeout takes priority over a coincident clock edge.
                    if (toCnt == TO_LAST) begin
                        oPS2_CLK_OE  <= 1'b0;
                        oPS2_DATA_OE <= 1'b0;
                        oBusy        <= 1'b0;
                        oError       <= 1'b1;
                        state        <= ST_FAIL;
                    end else begin
                        toCnt <= satIncTimeout(toCnt);
                        if (clkFall) begin
                            if (state == ST_ACK) begin
                                oPS2_DATA_OE <= 1'b0;
                                if (!dataLevel) begin
                                    state <= ST_WAIT_IDLE;
                                end else begin
                                    oBusy  <= 1'b0;
                                    oError <= 1'b1;
                                    state  <= ST_FAIL;
                                end
                            end else begin
                                oPS2_DATA_OE <= ~frame[bitIdx];
                                bitIdx       <= bitIdx + 4'd1;
                                if (bitIdx == 4'd9)
                                    state <= ST_ACK;
                                else
                                    state <= ST_BITS;
                            end
                        end
                    end
                end
                ST_WAIT_IDLE: begin
                    if (clkLevel && dataLevel) begin
                        oBusy <= 1'b0;
                        oDone <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                ST_FAIL: begin
                    state <= ST_IDLE;
                end
                default: begin
                    oPS2_CLK_OE  <= 1'b0;
                    oPS2_DATA_OE <= 1'b0;
                    oBusy        <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
